egress_arbiter: RTL
===================

EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4: number of ingress ports sharing one egress.
REQ-002 The block SHALL have parameter IDX_WIDTH, default $clog2(N_PORTS): width of the port index.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64: stall limit for a granted port, legal range 1..65535.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port ingress_valid  input  N_PORTS  per-port word valid; also the port's request.
REQ-007 The block SHALL have port ingress_eop  input  N_PORTS  per-port end-of-packet marker, qualified by ingress_valid.
REQ-008 The block SHALL have port ingress_ready  output  N_PORTS  per-port accept back-pressure.
REQ-009 The block SHALL have port egress_ready  input  1  downstream accept.
REQ-010 The block SHALL have port egress_valid  output  1  egress word valid.
REQ-011 The block SHALL have port egress_eop  output  1  egress end-of-packet.
REQ-012 The block SHALL have port selected_ingress  output  IDX_WIDTH  registered select driving the egress data mux.
REQ-013 The block SHALL have port grant_valid  output  1  high while a port owns the egress.
REQ-014 The block SHALL have port timeout_pulse  output  1  one-cycle pulse on a forced release.

Function
REQ-015 The block SHALL implement two states: IDLE and BUSY.
REQ-016 In IDLE, when any ingress_valid bit is high, the block SHALL select the first requesting port at or after rr_ptr in cyclic order (rr_ptr, rr_ptr+1, ... wrapping at N_PORTS-1 to 0).
REQ-017 The selection SHALL load selected_ingress and enter BUSY on the next edge; grant_valid SHALL equal (state==BUSY).
REQ-018 In IDLE, ingress_ready SHALL be all zero and egress_valid SHALL be 0; one arbitration bubble cycle per packet is required.
REQ-019 In BUSY: egress_valid SHALL be ingress_valid[sel]; egress_eop SHALL be ingress_eop[sel] & ingress_valid[sel]; ingress_ready[sel] SHALL be egress_ready; all other ingress_ready bits SHALL be 0 (combinational paths).
REQ-020 A transfer SHALL be defined as egress_valid & egress_ready in BUSY.
REQ-021 A transfer with egress_eop=1 SHALL return the block to IDLE on the next edge and set rr_ptr to (sel+1) mod N_PORTS.
REQ-022 selected_ingress SHALL hold its value throughout BUSY regardless of other ingress_valid changes, and SHALL hold its last value in IDLE until the next grant.
REQ-023 A stall counter (16 bits) SHALL clear on entry to BUSY and on every BUSY cycle with ingress_valid[sel]=1, and SHALL increment on each BUSY cycle with ingress_valid[sel]=0.
REQ-024 When the stall counter is TIMEOUT_CYCLES-1 and ingress_valid[sel]=0, the block SHALL on the next edge enter IDLE, set rr_ptr to (sel+1) mod N_PORTS, and assert timeout_pulse for exactly that following cycle.
REQ-025 egress_ready low with ingress_valid[sel] high SHALL NOT advance the stall counter, so downstream back-pressure never causes a timeout.
REQ-026 A single-word packet (valid and eop on the first word) SHALL be a complete packet, occupying one BUSY cycle when egress_ready=1.
REQ-027 When N_PORTS is not a power of two, rr_ptr and selected_ingress SHALL never take values >= N_PORTS.

Reset
REQ-028 Assertion of reset_n=0 SHALL, asynchronously and at any point including mid-packet, force state=IDLE, rr_ptr=0, selected_ingress=0, stall counter=0, and timeout_pulse=0, giving grant_valid=0, egress_valid=0, and ingress_ready=0.
REQ-029 After reset_n deasserts, the first arbitration SHALL favour port 0.

Verification
REQ-030 Scenario: after reset, ports 1 and 3 each send a 3-word packet with egress_ready=1 -> port 1 is granted first (selected_ingress=1, grant high 3 cycles); IDLE bubble; port 3 is granted; rr_ptr=0 afterwards.
REQ-031 Scenario: all 4 ports request continuously with 1-word packets -> grant order 0,1,2,3,0; each grant has 1 BUSY cycle plus 1 IDLE cycle.
REQ-032 Scenario: port 2 is granted, sends 1 word, then drops valid; TIMEOUT_CYCLES=8 -> after 8 idle BUSY cycles, timeout_pulse=1 for 1 cycle, state is IDLE, and port 3 is next in priority.
REQ-033 Scenario: port 0 is granted and egress_ready=0 for 100 cycles with valid held -> no timeout occurs, ingress_ready[0]=0 throughout, and the packet completes once ready rises.
REQ-034 Scenario: reset_n pulses low mid-packet on port 2 -> all outputs are 0 immediately without waiting for a clock edge; the next grant goes to the lowest requesting port from 0.
REQ-035 Scenario: port 1 is granted while port 0 asserts valid mid-packet -> selected_ingress stays 1 until port 1's eop transfer, and ingress_ready[0]=0 throughout.

Source files
------------

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : egress_arbiter
// Purpose  : Round-robin, packet-granular arbiter that lets N_PORTS ingress
//            ports share one egress. A port keeps the egress from its first
//            word through its end-of-packet transfer. A stall watchdog
//            forces a release if the granted port stops presenting words.
// Ports    : clk              - sole clock, rising edge
//            reset_n          - asynchronous active-low reset
//            ingress_valid    - per-port word valid; doubles as the request
//            ingress_eop      - per-port end-of-packet, qualified by valid
//            ingress_ready    - per-port accept, only the granted port sees it
//            egress_ready     - downstream accept
//            egress_valid     - egress word valid
//            egress_eop       - egress end-of-packet
//            selected_ingress - registered select for the egress data mux
//            grant_valid      - high while a port owns the egress
//            timeout_pulse    - one-cycle pulse on a forced release
// Revision : 1.0 - initial release
// ============================================================================
module egress_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int IDX_WIDTH      = $clog2(N_PORTS),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_PORTS-1:0]   ingress_valid,
  input  logic [N_PORTS-1:0]   ingress_eop,
  output logic [N_PORTS-1:0]   ingress_ready,
  input  logic                 egress_ready,
  output logic                 egress_valid,
  output logic                 egress_eop,
  output logic [IDX_WIDTH-1:0] selected_ingress,
  output logic                 grant_valid,
  output logic                 timeout_pulse
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH:0]   c_NPORTS      = (IDX_WIDTH+1)'(N_PORTS);
  localparam logic [IDX_WIDTH-1:0] c_LAST_PORT   = IDX_WIDTH'(N_PORTS - 1);
  localparam logic [15:0]          c_STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [IDX_WIDTH-1:0] r_rr_ptr;
  logic [IDX_WIDTH-1:0] r_sel;
  logic [15:0]          r_stall;
  logic                 r_timeout;

  logic                 w_busy;
  logic                 w_sel_valid;
  logic                 w_sel_eop;
  logic [IDX_WIDTH-1:0] w_sel_next;
  logic                 w_found;
  logic [IDX_WIDTH-1:0] w_pick;
  logic [IDX_WIDTH:0]   w_cand;

  assign w_busy      = (r_state == S_BUSY);
  assign w_sel_valid = ingress_valid[r_sel];
  assign w_sel_eop   = ingress_eop[r_sel];
  // Wrap explicitly so a non-power-of-two port count never yields an
  // out-of-range pointer.
  assign w_sel_next  = (r_sel == c_LAST_PORT) ? '0 : r_sel + 1'b1;

  // Scan ports starting at the round-robin pointer. The candidate is one bit
  // wider than the index so rr_ptr+i cannot overflow before the wrap test.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_WIDTH+1)'(i);
      if (w_cand >= c_NPORTS) begin
        w_cand = w_cand - c_NPORTS;
      end
      if (!w_found && ingress_valid[w_cand[IDX_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_WIDTH-1:0];
      end
    end
  end

  // Egress handshake is a pure combinational pass-through of the granted
  // port; nothing is presented during the IDLE arbitration bubble.
  always_comb begin
    ingress_ready = '0;
    if (w_busy) begin
      ingress_ready[r_sel] = egress_ready;
    end
  end

  assign egress_valid     = w_busy & w_sel_valid;
  assign egress_eop       = w_busy & w_sel_valid & w_sel_eop;
  assign grant_valid      = w_busy;
  assign selected_ingress = r_sel;
  assign timeout_pulse    = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel   <= w_pick;
            r_stall <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_sel_valid) begin
            // A presented word, even one held off by back-pressure, proves
            // the port is alive, so the watchdog restarts.
            r_stall <= '0;
            if (egress_ready && w_sel_eop) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_sel_next;
            end
          end else if (r_stall == c_STALL_LIMIT) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= w_sel_next;
            r_stall   <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
